nx_axi4s_out_fifo: RTL and testbench

NX_AXI4S_OUT_FIFO -- requirements
Module: nx_axi4s_out_fifo

---
 rtl/nx_axi4s_out_fifo.sv | 194 +++++++++++++++++++
 tb/tb_nx_axi4s_out_fifo.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_axi4s_out_fifo.sv
// -----------------------------------------------------------------------------
// nx_axi4s_out_fifo
//
// Output FIFO for an AXI4-Stream path. It buffers DEPTH beats between the
// interface-monitor pipe and the downstream sink. It also keeps simple
// delivery statistics and checks that tid stays constant inside an input frame.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous, active-high reset
//   in_t*          upstream beat: tvalid/tdata/tstrb/tuser/tid/tlast
//   in_tready      FIFO can accept a beat (registered state only)
//   out_t*         downstream beat taken from the read-pointer entry
//   out_tready     downstream accepts the presented beat
//   stat_clr       clears frame_cnt, beat_cnt and tid_err
//   occupancy      number of entries held (0..DEPTH)
//   frame_cnt      frames (tlast beats) delivered downstream, wraps at 2^16
//   beat_cnt       beats delivered so far in the current downstream frame
//   tid_err        sticky: tid changed in the middle of an input frame
// -----------------------------------------------------------------------------
module nx_axi4s_out_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_tvalid,
    input  logic [DW-1:0]              in_tdata,
    input  logic [DW/8-1:0]            in_tstrb,
    input  logic [7:0]                 in_tuser,
    input  logic                       in_tid,
    input  logic                       in_tlast,
    output logic                       in_tready,
    output logic                       out_tvalid,
    output logic [DW-1:0]              out_tdata,
    output logic [DW/8-1:0]            out_tstrb,
    output logic [7:0]                 out_tuser,
    output logic                       out_tid,
    output logic                       out_tlast,
    input  logic                       out_tready,
    input  logic                       stat_clr,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [15:0]                frame_cnt,
    output logic [15:0]                beat_cnt,
    output logic                       tid_err
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);

    // The pointers wrap by natural overflow, so the depth must be a power of two.
    generate
        if ((DEPTH < 2) || (DEPTH > 16) || ((1 << AW) != DEPTH)) begin : g_bad_depth
            $error("nx_axi4s_out_fifo: DEPTH must be a power of two in 2..16");
        end
    endgenerate

    typedef enum logic {
        TRK_IDLE,
        TRK_IN_FRAME
    } trk_state_t;

    // -------------------------------------------------------------------------
    // Storage and pointers
    // -------------------------------------------------------------------------
    logic [DW-1:0]   data_mem [DEPTH];
    logic [DW/8-1:0] strb_mem [DEPTH];
    logic [7:0]      user_mem [DEPTH];
    logic            tid_mem  [DEPTH];
    logic            last_mem [DEPTH];

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_nxt;

    logic            push;
    logic            pop;

    trk_state_t      trk_state;
    logic            frame_tid;

    // Both handshakes depend only on the registered count, so there is no
    // combinational path from out_tready to in_tready.
    assign in_tready  = (count != FULL_CNT);
    assign out_tvalid = (count != '0);

    assign push = in_tvalid  & in_tready;
    assign pop  = out_tvalid & out_tready;

    // Read data comes straight from the entry under the read pointer. It only
    // changes when rd_ptr moves (a pop), which keeps the fields stable while
    // the sink stalls.
    assign out_tdata = data_mem[rd_ptr];
    assign out_tstrb = strb_mem[rd_ptr];
    assign out_tuser = user_mem[rd_ptr];
    assign out_tid   = tid_mem[rd_ptr];
    assign out_tlast = last_mem[rd_ptr];

    assign occupancy = count;

    // NOTE: every variable assigned in always_comb gets a default first, so a
    // missing case arm can never infer a latch.
    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // always_ff reads the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_nxt;
        end
    end

    // NOTE: the storage array is deliberately not reset. Entries are only
    // observable once out_tvalid is set, and a reset-free array maps onto
    // plain RAM or a register file.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= in_tdata;
            strb_mem[wr_ptr] <= in_tstrb;
            user_mem[wr_ptr] <= in_tuser;
            tid_mem[wr_ptr]  <= in_tid;
            last_mem[wr_ptr] <= in_tlast;
        end
    end

    // -------------------------------------------------------------------------
    // Input frame tracker and sticky tid error
    // -------------------------------------------------------------------------
    // The tracker follows accepted beats only. A tid mismatch is flagged, but
    // the beat is still stored unchanged. stat_clr clears the flag without
    // disturbing the tracker state.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_state <= TRK_IDLE;
            frame_tid <= 1'b0;
            tid_err   <= 1'b0;
        end else begin
            if (push) begin
                unique case (trk_state)
                    TRK_IDLE: begin
                        frame_tid <= in_tid;
                        if (!in_tlast) trk_state <= TRK_IN_FRAME;
                    end
                    TRK_IN_FRAME: begin
                        if (in_tlast) trk_state <= TRK_IDLE;
                    end
                    default: trk_state <= TRK_IDLE;
                endcase
            end

            if (stat_clr) begin
                tid_err <= 1'b0;
            end else if (push && (trk_state == TRK_IN_FRAME) && (in_tid != frame_tid)) begin
                tid_err <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Delivery statistics
    // -------------------------------------------------------------------------
    // A clear takes priority over a pop in the same cycle, so that pop is not
    // counted.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            frame_cnt <= '0;
            beat_cnt  <= '0;
        end else if (pop) begin
            if (out_tlast) begin
                beat_cnt  <= '0;
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                beat_cnt  <= beat_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nx_axi4s_out_fifo.sv
// -----------------------------------------------------------------------------
// tb_nx_axi4s_out_fifo
//
// Scoreboard bench for nx_axi4s_out_fifo (DEPTH=4, DW=64). The driver pushes
// each beat into exp_q when the FIFO accepts it. A separate monitor pops
// exp_q and compares it with the beat whenever the DUT completes an output
// handshake. The monitor also tracks the expected delivery counters and the
// hold rule while the sink stalls. Directed phases check occupancy,
// in_tready, tid_err and the counters against hand-computed values.
// -----------------------------------------------------------------------------
module tb_nx_axi4s_out_fifo;

    localparam int DEPTH = 4;
    localparam int DW    = 64;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic [7:0]  user;
        logic        tid;
        logic        last;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_tvalid;
    logic [DW-1:0]          in_tdata;
    logic [DW/8-1:0]        in_tstrb;
    logic [7:0]             in_tuser;
    logic                   in_tid;
    logic                   in_tlast;
    logic                   in_tready;
    logic                   out_tvalid;
    logic [DW-1:0]          out_tdata;
    logic [DW/8-1:0]        out_tstrb;
    logic [7:0]             out_tuser;
    logic                   out_tid;
    logic                   out_tlast;
    logic                   out_tready;
    logic                   stat_clr;
    logic [$clog2(DEPTH):0] occupancy;
    logic [15:0]            frame_cnt;
    logic [15:0]            beat_cnt;
    logic                   tid_err;

    nx_axi4s_out_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_tvalid  (in_tvalid),
        .in_tdata   (in_tdata),
        .in_tstrb   (in_tstrb),
        .in_tuser   (in_tuser),
        .in_tid     (in_tid),
        .in_tlast   (in_tlast),
        .in_tready  (in_tready),
        .out_tvalid (out_tvalid),
        .out_tdata  (out_tdata),
        .out_tstrb  (out_tstrb),
        .out_tuser  (out_tuser),
        .out_tid    (out_tid),
        .out_tlast  (out_tlast),
        .out_tready (out_tready),
        .stat_clr   (stat_clr),
        .occupancy  (occupancy),
        .frame_cnt  (frame_cnt),
        .beat_cnt   (beat_cnt),
        .tid_err    (tid_err)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    beat_t exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hand-derived sideband pattern, so that strb/user differ from beat to beat.
    function automatic beat_t mk(input logic [63:0] d, input logic tid, input logic last);
        beat_t b;
        b.data = d;
        b.strb = 8'hFF >> d[2:0];
        b.user = d[7:0] ^ 8'hA5;
        b.tid  = tid;
        b.last = last;
        return b;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input beat_t b);
        in_tvalid = 1'b1;
        in_tdata  = b.data;
        in_tstrb  = b.strb;
        in_tuser  = b.user;
        in_tid    = b.tid;
        in_tlast  = b.last;
    endtask

    // Presents a beat and holds it until accepted. The expected copy enters
    // the scoreboard in the cycle the handshake happens.
    task automatic send_beat(input beat_t b);
        drive(b);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (in_tready) begin
                exp_q.push_back(b);
                @(posedge clk);
                #1;
                return;
            end
        end
        check("send_timeout", 1, 0);
        in_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 5000; i++) begin
            if (exp_q.size() == 0 && !out_tvalid) return;
            tick();
        end
        check("drain_timeout", 1, 0);
    endtask

    // ---------------------------------------------------------------- monitor
    beat_t       got;
    beat_t       exp_b;
    beat_t       held;
    logic        hold_pending = 1'b0;
    logic [15:0] exp_beat  = '0;
    logic [15:0] exp_frame = '0;
    logic        pop_last;

    always @(negedge clk) begin
        got = {out_tdata, out_tstrb, out_tuser, out_tid, out_tlast};
        if (rst) begin
            exp_beat     = '0;
            exp_frame    = '0;
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", out_tvalid, 1);
                check("hold_fields", got, held);
            end
            pop_last = 1'b0;
            if (out_tvalid && out_tready) begin
                check("beat_cnt_live", beat_cnt, exp_beat);
                check("frame_cnt_live", frame_cnt, exp_frame);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", got, 0);
                    pop_last = got.last;
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat", got, exp_b);
                    pop_last = exp_b.last;
                end
            end
            hold_pending = out_tvalid && !out_tready;
            held         = got;
            if (stat_clr) begin
                exp_beat  = '0;
                exp_frame = '0;
            end else if (out_tvalid && out_tready) begin
                if (pop_last) begin
                    exp_beat  = '0;
                    exp_frame = exp_frame + 16'd1;
                end else begin
                    exp_beat = exp_beat + 16'd1;
                end
            end
        end
    end

    // Peak occupancy during the streaming phase.
    logic track_occ = 1'b0;
    int   max_occ   = 0;
    always @(negedge clk) begin
        if (track_occ && int'(occupancy) > max_occ) max_occ = int'(occupancy);
    end

    // -------------------------------------------------------------- stimulus
    logic  running;
    int    t0;
    int    t1;
    int    n_last;
    beat_t rb;

    initial begin
        rst        = 1'b1;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        in_tstrb   = '0;
        in_tuser   = '0;
        in_tid     = 1'b0;
        in_tlast   = 1'b0;
        out_tready = 1'b0;
        stat_clr   = 1'b0;
        running    = 1'b0;
        n_last     = 0;

        // Reset state
        tick(2);
        check("rst_in_tready", in_tready, 1);
        check("rst_out_tvalid", out_tvalid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_tid_err", tid_err, 0);
        rst = 1'b0;
        tick();

        // Fill with four beats while the sink stalls, hold a fifth beat, then drain
        for (int i = 1; i <= 4; i++) send_beat(mk(64'(i), 1'b0, i == 4));
        check("fill_occupancy", occupancy, 4);
        check("fill_in_tready", in_tready, 0);
        drive(mk(64'd5, 1'b0, 1'b1));
        tick(2);
        check("held_occupancy", occupancy, 4);
        check("held_in_tready", in_tready, 0);
        out_tready = 1'b1;
        send_beat(mk(64'd5, 1'b0, 1'b1));
        in_tvalid = 1'b0;
        wait_drain();
        check("fill_frame_cnt", frame_cnt, 2);
        check("fill_beat_cnt", beat_cnt, 0);

        // 100 back-to-back beats with the sink always ready
        max_occ   = 0;
        track_occ = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 100; i++) send_beat(mk(64'h100 + 64'(i), 1'b1, (i % 10) == 9));
        t1 = cyc;
        track_occ = 1'b0;
        in_tvalid = 1'b0;
        check("stream_cycles", t1 - t0, 100);
        wait_drain();
        check("stream_max_occ", max_occ, 1);
        check("stream_frame_cnt", frame_cnt, 12);

        // Full FIFO offered a push and a pop together: only the pop happens
        out_tready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(mk(64'h200 + 64'(i), 1'b0, i == 3));
        drive(mk(64'h255, 1'b0, 1'b1));
        out_tready = 1'b1;
        check("full_pp_in_tready", in_tready, 0);
        check("full_pp_occ_before", occupancy, 4);
        tick();
        out_tready = 1'b0;
        check("full_pp_occ_after", occupancy, 3);
        check("full_pp_in_tready_after", in_tready, 1);
        send_beat(mk(64'h255, 1'b0, 1'b1));
        in_tvalid = 1'b0;
        check("full_pp_refill", occupancy, 4);
        out_tready = 1'b1;
        wait_drain();
        check("full_pp_frame_cnt", frame_cnt, 14);

        // tid changes on the last beat of a frame: sticky error until stat_clr
        check("tid_err_clean", tid_err, 0);
        send_beat(mk(64'h301, 1'b0, 1'b0));
        send_beat(mk(64'h302, 1'b0, 1'b0));
        check("tid_err_same_tid", tid_err, 0);
        send_beat(mk(64'h303, 1'b1, 1'b1));
        in_tvalid = 1'b0;
        check("tid_err_set", tid_err, 1);
        wait_drain();
        tick(3);
        check("tid_err_sticky", tid_err, 1);
        check("tid_frame_cnt", frame_cnt, 15);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("tid_err_cleared", tid_err, 0);
        check("clr_frame_cnt", frame_cnt, 0);
        check("clr_beat_cnt", beat_cnt, 0);

        // A pop in the same cycle as stat_clr is not counted
        out_tready = 1'b0;
        send_beat(mk(64'h350, 1'b0, 1'b1));
        in_tvalid  = 1'b0;
        stat_clr   = 1'b1;
        out_tready = 1'b1;
        tick();
        stat_clr   = 1'b0;
        out_tready = 1'b0;
        check("clr_wins_frame_cnt", frame_cnt, 0);
        check("clr_wins_occupancy", occupancy, 0);

        // Random valid/ready, 10,000 beats against the scoreboard
        running = 1'b1;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    while ($urandom_range(1) == 1) begin
                        in_tvalid = 1'b0;
                        tick();
                    end
                    rb.data = {$urandom, $urandom};
                    rb.strb = 8'($urandom);
                    rb.user = 8'($urandom);
                    rb.tid  = 1'($urandom);
                    rb.last = ($urandom_range(7) == 0);
                    if (rb.last) n_last++;
                    send_beat(rb);
                end
                in_tvalid = 1'b0;
                running   = 1'b0;
            end
            begin
                while (running) begin
                    out_tready = 1'($urandom_range(1));
                    tick();
                end
            end
        join
        out_tready = 1'b1;
        wait_drain();
        check("rand_frame_cnt", frame_cnt, 16'(n_last));

        // Reset in the middle of a frame with three entries held
        out_tready = 1'b0;
        send_beat(mk(64'h401, 1'b0, 1'b0));
        send_beat(mk(64'h402, 1'b1, 1'b0));
        send_beat(mk(64'h403, 1'b1, 1'b0));
        in_tvalid = 1'b0;
        check("pre_rst_occupancy", occupancy, 3);
        check("pre_rst_tid_err", tid_err, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_out_tvalid", out_tvalid, 0);
        check("mid_rst_occupancy", occupancy, 0);
        check("mid_rst_in_tready", in_tready, 1);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_beat_cnt", beat_cnt, 0);
        check("mid_rst_tid_err", tid_err, 0);
        rst = 1'b0;
        exp_q.delete();
        out_tready = 1'b1;
        send_beat(mk(64'h4A0, 1'b1, 1'b0));
        send_beat(mk(64'h4A1, 1'b1, 1'b1));
        in_tvalid = 1'b0;
        wait_drain();
        check("post_rst_frame_cnt", frame_cnt, 1);
        check("post_rst_tid_err", tid_err, 0);
        check("post_rst_occupancy", occupancy, 0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
